// File: rtl/hasti_xbar_nxm.sv
// AHB-lite (HASTI) NM x NS crossbar.
// Per-slave round-robin arbitration with burst/lock hold, lowest-index
// address decode and a per-master default slave that answers ERROR for
// unmapped NONSEQ/SEQ transfers. Address and return paths are combinational;
// only grants, round-robin pointers and data-phase owners are registered.
module hasti_xbar_nxm #(
   parameter int NM = 2,
   parameter int NS = 3,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter logic [NS*AW-1:0] SLV_BASE = '0,
   parameter logic [NS*AW-1:0] SLV_MASK = '0
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic [NM*AW-1:0] m_haddr,
   input  logic [NM-1:0]    m_hwrite,
   input  logic [NM*3-1:0]  m_hsize,
   input  logic [NM*3-1:0]  m_hburst,
   input  logic [NM*4-1:0]  m_hprot,
   input  logic [NM*2-1:0]  m_htrans,
   input  logic [NM-1:0]    m_hmastlock,
   input  logic [NM*DW-1:0] m_hwdata,
   output logic [NM*DW-1:0] m_hrdata,
   output logic [NM-1:0]    m_hready,
   output logic [NM-1:0]    m_hresp,
   output logic [NS-1:0]    s_hsel,
   output logic [NS*AW-1:0] s_haddr,
   output logic [NS-1:0]    s_hwrite,
   output logic [NS*3-1:0]  s_hsize,
   output logic [NS*3-1:0]  s_hburst,
   output logic [NS*4-1:0]  s_hprot,
   output logic [NS*2-1:0]  s_htrans,
   output logic [NS-1:0]    s_hmastlock,
   output logic [NS*DW-1:0] s_hwdata,
   output logic [NS-1:0]    s_hready,
   input  logic [NS-1:0]    s_hreadyout,
   input  logic [NS-1:0]    s_hresp,
   input  logic [NS*DW-1:0] s_hrdata
);

   localparam int MW = (NM > 1) ? $clog2(NM) : 1;
   localparam int SW = $clog2(NS + 1);
   // slave index NS stands for the built-in default slave
   localparam logic [SW-1:0] DEF = SW'(NS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] SEQ  = 2'd3;

   logic [SW-1:0] tgt [NM];
   logic [NS-1:0] req [NM];
   logic [NM-1:0] slv_req, def_req;

   logic [NM-1:0] dp_ready, dp_resp;
   logic [DW-1:0] dp_rdata [NM];

   logic [MW-1:0] gnt [NS];
   logic [NS-1:0] gnt_v, acc;
   logic [MW-1:0] gnt_q [NS];
   logic [NS-1:0] gnt_v_q;
   logic [MW-1:0] ptr_q [NS];
   logic [MW-1:0] dmst [NS];
   logic [NS-1:0] dmst_v;

   logic [SW-1:0] dslv [NM];
   logic [NM-1:0] dslv_v, err1;
   logic [NM-1:0] macc, hready_int;

   assign s_hready = s_hreadyout;

   // address decode: lowest matching slave wins, no match goes to default slave
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         tgt[i] = DEF;
         for (int j = NS - 1; j >= 0; j--)
            if ((m_haddr[i*AW +: AW] & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW])
               tgt[i] = SW'(j);
         slv_req[i] = m_htrans[i*2+1] && (tgt[i] != DEF);
         def_req[i] = m_htrans[i*2+1] && (tgt[i] == DEF);
         for (int j = 0; j < NS; j++)
            req[i][j] = slv_req[i] && (tgt[i] == SW'(j));
      end
   end

   // data-phase return path selected by the recorded data-phase slave
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         dp_ready[i] = 1'b1;
         dp_resp[i]  = 1'b0;
         dp_rdata[i] = '0;
         if (dslv_v[i] && (dslv[i] == DEF)) begin
            dp_ready[i] = !err1[i];
            dp_resp[i]  = 1'b1;
         end
         for (int j = 0; j < NS; j++)
            if (dslv_v[i] && (dslv[i] == SW'(j))) begin
               dp_ready[i] = s_hreadyout[j];
               dp_resp[i]  = s_hresp[j];
               dp_rdata[i] = s_hrdata[j*DW +: DW];
            end
      end
   end

   // per-slave arbitration; a master still stalled in another data phase is not eligible
   always_comb begin : arb
      logic hold;
      for (int j = 0; j < NS; j++) begin
         gnt[j]   = gnt_q[j];
         gnt_v[j] = gnt_v_q[j];
         hold     = 1'b0;
         for (int i = 0; i < NM; i++)
            if (gnt_v_q[j] && (gnt_q[j] == MW'(i)))
               hold = m_hmastlock[i] || (m_htrans[i*2 +: 2] == SEQ) ||
                      (m_htrans[i*2 +: 2] == BUSY);
         if (s_hreadyout[j] && !hold) begin
            gnt_v[j] = 1'b0;
            gnt[j]   = '0;
            for (int i = 0; i < NM; i++)
               if (!gnt_v[j] && (MW'(i) >= ptr_q[j]) && req[i][j] && dp_ready[i]) begin
                  gnt_v[j] = 1'b1;
                  gnt[j]   = MW'(i);
               end
            for (int i = 0; i < NM; i++)
               if (!gnt_v[j] && req[i][j] && dp_ready[i]) begin
                  gnt_v[j] = 1'b1;
                  gnt[j]   = MW'(i);
               end
         end
         acc[j] = 1'b0;
         for (int i = 0; i < NM; i++)
            if (gnt_v[j] && (gnt[j] == MW'(i)))
               acc[j] = s_hreadyout[j] && req[i][j] && dp_ready[i];
      end
   end

   // slave-side address/control mux and write-data mux
   always_comb begin
      s_hsel      = '0;
      s_haddr     = '0;
      s_hwrite    = '0;
      s_hsize     = '0;
      s_hburst    = '0;
      s_hprot     = '0;
      s_htrans    = '0;
      s_hmastlock = '0;
      s_hwdata    = '0;
      for (int j = 0; j < NS; j++) begin
         for (int i = 0; i < NM; i++) begin
            if (gnt_v[j] && (gnt[j] == MW'(i)) && dp_ready[i]) begin
               s_hsel[j]            = 1'b1;
               s_haddr[j*AW +: AW]  = m_haddr[i*AW +: AW];
               s_hwrite[j]          = m_hwrite[i];
               s_hsize[j*3 +: 3]    = m_hsize[i*3 +: 3];
               s_hburst[j*3 +: 3]   = m_hburst[i*3 +: 3];
               s_hprot[j*4 +: 4]    = m_hprot[i*4 +: 4];
               s_hmastlock[j]       = m_hmastlock[i];
               s_htrans[j*2 +: 2]   = (req[i][j] || (m_htrans[i*2 +: 2] == BUSY)) ?
                                      m_htrans[i*2 +: 2] : IDLE;
            end
            if (dmst_v[j] && (dmst[j] == MW'(i)))
               s_hwdata[j*DW +: DW] = m_hwdata[i*DW +: DW];
         end
      end
      if (hreset) begin
         s_hsel      = '0;
         s_haddr     = '0;
         s_hwrite    = '0;
         s_hsize     = '0;
         s_hburst    = '0;
         s_hprot     = '0;
         s_htrans    = '0;
         s_hmastlock = '0;
         s_hwdata    = '0;
      end
   end

   // master-side ready/response/read-data
   always_comb begin
      for (int i = 0; i < NM; i++) begin
         macc[i] = 1'b0;
         for (int j = 0; j < NS; j++)
            if (acc[j] && (gnt[j] == MW'(i)))
               macc[i] = 1'b1;
         hready_int[i] = dp_ready[i] && (!slv_req[i] || macc[i]);
         m_hready[i]   = hreset ? 1'b1 : hready_int[i];
         m_hresp[i]    = hreset ? 1'b0 : dp_resp[i];
         m_hrdata[i*DW +: DW] = hreset ? '0 : dp_rdata[i];
      end
   end

   // grant, round-robin pointer and data-phase master per slave
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         gnt_v_q <= '0;
         dmst_v  <= '0;
         for (int j = 0; j < NS; j++) begin
            gnt_q[j] <= '0;
            ptr_q[j] <= '0;
            dmst[j]  <= '0;
         end
      end else begin
         gnt_v_q <= gnt_v;
         for (int j = 0; j < NS; j++) begin
            gnt_q[j] <= gnt[j];
            if (s_hreadyout[j]) begin
               if (gnt_v[j])
                  ptr_q[j] <= (gnt[j] == MW'(NM - 1)) ? '0 : gnt[j] + 1'b1;
               dmst_v[j] <= acc[j];
               dmst[j]   <= gnt[j];
            end
         end
      end
   end

   // data-phase slave per master; default-slave ERROR lasts two cycles
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         dslv_v <= '0;
         err1   <= '0;
         for (int i = 0; i < NM; i++)
            dslv[i] <= '0;
      end else begin
         for (int i = 0; i < NM; i++) begin
            if (hready_int[i]) begin
               dslv_v[i] <= macc[i] || def_req[i];
               dslv[i]   <= tgt[i];
               err1[i]   <= def_req[i];
            end else begin
               err1[i]   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hasti_xbar_nxm.sv
module tb_hasti_xbar_nxm;
   localparam int NM = 2;
   localparam int NS = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
   localparam logic [31:0] K = 32'h5A5A_0000;
   localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;

   logic             hclk = 1'b0;
   logic             hreset = 1'b1;
   logic [NM*AW-1:0] m_haddr;
   logic [NM-1:0]    m_hwrite;
   logic [NM*3-1:0]  m_hsize;
   logic [NM*3-1:0]  m_hburst;
   logic [NM*4-1:0]  m_hprot;
   logic [NM*2-1:0]  m_htrans;
   logic [NM-1:0]    m_hmastlock;
   logic [NM*DW-1:0] m_hwdata;
   logic [NM*DW-1:0] m_hrdata;
   logic [NM-1:0]    m_hready;
   logic [NM-1:0]    m_hresp;
   logic [NS-1:0]    s_hsel;
   logic [NS*AW-1:0] s_haddr;
   logic [NS-1:0]    s_hwrite;
   logic [NS*3-1:0]  s_hsize;
   logic [NS*3-1:0]  s_hburst;
   logic [NS*4-1:0]  s_hprot;
   logic [NS*2-1:0]  s_htrans;
   logic [NS-1:0]    s_hmastlock;
   logic [NS*DW-1:0] s_hwdata;
   logic [NS-1:0]    s_hready;
   logic [NS-1:0]    s_hreadyout;
   logic [NS-1:0]    s_hresp;
   logic [NS*DW-1:0] s_hrdata;

   hasti_xbar_nxm #(
      .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SLV_BASE(BASE), .SLV_MASK(MASK)
   ) dut (
      .hclk(hclk), .hreset(hreset),
      .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hprot(m_hprot), .m_htrans(m_htrans), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
      .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
      .s_hburst(s_hburst), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hmastlock(s_hmastlock),
      .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hreadyout(s_hreadyout),
      .s_hresp(s_hresp), .s_hrdata(s_hrdata)
   );

   always #5 hclk = ~hclk;

   int cyc = 0;
   always @(posedge hclk) cyc <= cyc + 1;

   // zero-wait slave model: read data = captured address ^ K in the data phase
   logic [DW-1:0] rd_q [NS];
   initial for (int j = 0; j < NS; j++) rd_q[j] = '0;
   always @(posedge hclk)
      for (int j = 0; j < NS; j++)
         if (s_hsel[j] && s_hready[j] && s_htrans[j*2+1])
            rd_q[j] <= s_haddr[j*AW +: AW] ^ K;
   always_comb begin
      s_hrdata = '0;
      for (int j = 0; j < NS; j++) s_hrdata[j*DW +: DW] = rd_q[j];
   end

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int errors = 0;
   logic done = 1'b0;
   logic fin_chk = 1'b0;

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         0: obs = 32'(s_hsel);
         1: obs = 32'(m_hready);
         2: obs = 32'(m_hresp);
         3: obs = m_hrdata[0 +: DW];
         4: obs = m_hrdata[DW +: DW];
         5: obs = s_haddr[0 +: AW];
         6: obs = s_haddr[AW +: AW];
         7: obs = s_haddr[2*AW +: AW];
         8: obs = 32'(s_htrans);
         default: obs = 32'hDEAD_BEEF;
      endcase
   endfunction

   // monitor: pops expectations for the current cycle and compares away from the edge
   always @(negedge hclk) begin
      exp_t e;
      logic [31:0] got;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e = sbq.pop_front();
         checks++;
         got = obs(e.sel);
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: stale expectation cyc %0d at cyc %0d", e.name, e.cyc, cyc);
         end else if (got !== e.val) begin
            errors++;
            $display("FAIL %s: cyc %0d got %h want %h", e.name, cyc, got, e.val);
         end
      end
      if (done && !fin_chk) begin
         fin_chk = 1'b1;
         checks++;
         if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d pending expectations, want 0", sbq.size());
         end
      end
   end

   task automatic push(input int sel, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc = cyc; e.sel = sel; e.val = v; e.name = n;
      sbq.push_back(e);
   endtask

   task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] a,
                      input logic lk, input logic [2:0] bu);
      m_htrans[i*2 +: 2]  = tr;
      m_haddr[i*AW +: AW] = a;
      m_hmastlock[i]      = lk;
      m_hburst[i*3 +: 3]  = bu;
   endtask

   task automatic idle();
      drv(0, IDLE, 32'h0, 1'b0, 3'd0);
      drv(1, IDLE, 32'h0, 1'b0, 3'd0);
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      m_hwrite = '0; m_hsize = {NM{3'd2}}; m_hprot = '0; m_hwdata = '0;
      m_haddr = '0; m_htrans = '0; m_hmastlock = '0; m_hburst = '0;
      s_hreadyout = '1; s_hresp = '0;

      // reset held while m0 requests: outputs forced to reset values
      step();
      drv(0, NONSEQ, 32'h1000_0000, 1'b0, 3'd0);
      push(0, 32'h0, "rst_hsel");
      push(1, 32'h3, "rst_hready");
      push(2, 32'h0, "rst_hresp");
      push(3, 32'h0, "rst_hrdata0");
      push(8, 32'h0, "rst_htrans");
      step(); hreset = 1'b0; idle();

      // 1: single read to slave1
      step(); drv(0, NONSEQ, 32'h1000_0040, 1'b0, 3'd0);
      push(0, 32'h2, "t1_hsel");
      push(1, 32'h3, "t1_hready");
      push(6, 32'h1000_0040, "t1_haddr1");
      step(); idle();
      push(0, 32'h0, "t1_dp_hsel");
      push(1, 32'h3, "t1_dp_hready");
      push(2, 32'h0, "t1_dp_hresp");
      push(3, 32'h1000_0040 ^ K, "t1_rdata0");

      // 2: both masters on slave0, alternating grants
      step(); drv(0, NONSEQ, 32'h10, 1'b0, 3'd0); drv(1, NONSEQ, 32'h20, 1'b0, 3'd0);
      push(0, 32'h1, "t2_b0_hsel"); push(1, 32'h1, "t2_b0_hready"); push(5, 32'h10, "t2_b0_haddr");
      step(); drv(0, NONSEQ, 32'h14, 1'b0, 3'd0);
      push(1, 32'h2, "t2_b1_hready"); push(5, 32'h20, "t2_b1_haddr");
      step(); drv(1, NONSEQ, 32'h24, 1'b0, 3'd0);
      push(1, 32'h1, "t2_b2_hready"); push(5, 32'h14, "t2_b2_haddr");
      step(); drv(0, IDLE, 32'h0, 1'b0, 3'd0);
      push(1, 32'h3, "t2_b3_hready"); push(5, 32'h24, "t2_b3_haddr");
      step(); idle();
      push(0, 32'h0, "t2_idle_hsel");

      // 3: prime slave2 pointer, then m1 INCR4 burst blocks m0 for 4 beats
      step(); drv(0, NONSEQ, 32'h2000_0000, 1'b0, 3'd0);
      push(0, 32'h4, "t3_prime_hsel");
      step(); idle();
      step(); drv(1, NONSEQ, 32'h2000_0100, 1'b0, 3'd3); drv(0, NONSEQ, 32'h2000_0800, 1'b0, 3'd0);
      push(0, 32'h4, "t3_d0_hsel"); push(1, 32'h2, "t3_d0_hready"); push(7, 32'h2000_0100, "t3_d0_haddr");
      step(); drv(1, SEQ, 32'h2000_0104, 1'b0, 3'd3);
      push(1, 32'h2, "t3_d1_hready"); push(7, 32'h2000_0104, "t3_d1_haddr");
      push(8, 32'h30, "t3_d1_htrans"); push(4, 32'h2000_0100 ^ K, "t3_d1_rdata1");
      step(); drv(1, SEQ, 32'h2000_0108, 1'b0, 3'd3);
      push(1, 32'h2, "t3_d2_hready");
      step(); drv(1, SEQ, 32'h2000_010C, 1'b0, 3'd3);
      push(1, 32'h2, "t3_d3_hready"); push(7, 32'h2000_010C, "t3_d3_haddr");
      step(); drv(1, IDLE, 32'h0, 1'b0, 3'd0);
      push(1, 32'h3, "t3_d4_hready"); push(7, 32'h2000_0800, "t3_d4_haddr"); push(0, 32'h4, "t3_d4_hsel");
      step(); idle();
      push(3, 32'h2000_0800 ^ K, "t3_rdata0");

      // 4: unmapped address -> two-cycle ERROR from default slave
      step(); drv(0, NONSEQ, 32'hFFFF_0000, 1'b0, 3'd0);
      push(0, 32'h0, "t4_e0_hsel"); push(1, 32'h3, "t4_e0_hready"); push(2, 32'h0, "t4_e0_hresp");
      step(); idle();
      push(0, 32'h0, "t4_e1_hsel"); push(1, 32'h2, "t4_e1_hready"); push(2, 32'h1, "t4_e1_hresp");
      step();
      push(1, 32'h3, "t4_e2_hready"); push(2, 32'h1, "t4_e2_hresp");
      step();
      push(2, 32'h0, "t4_e3_hresp");

      // 5: locked sequence on slave0 holds off m1
      step(); drv(0, NONSEQ, 32'h100, 1'b1, 3'd0); drv(1, NONSEQ, 32'h200, 1'b0, 3'd0);
      push(1, 32'h1, "t5_f0_hready"); push(5, 32'h100, "t5_f0_haddr");
      step(); drv(0, NONSEQ, 32'h104, 1'b1, 3'd0);
      push(1, 32'h1, "t5_f1_hready"); push(5, 32'h104, "t5_f1_haddr");
      step(); drv(0, NONSEQ, 32'h108, 1'b1, 3'd0);
      push(1, 32'h1, "t5_f2_hready");
      step(); drv(0, IDLE, 32'h0, 1'b0, 3'd0);
      push(1, 32'h3, "t5_f3_hready"); push(5, 32'h200, "t5_f3_haddr");
      step(); idle();

      // 6: reset mid-burst, then master 0 wins first
      step(); drv(1, NONSEQ, 32'h2000_0100, 1'b0, 3'd3);
      push(0, 32'h4, "t6_g0_hsel");
      step(); drv(1, SEQ, 32'h2000_0104, 1'b0, 3'd3); drv(0, NONSEQ, 32'h2000_0900, 1'b0, 3'd0);
      push(1, 32'h3, "t6_rst_hready"); push(0, 32'h0, "t6_rst_hsel");
      #1 hreset = 1'b1;
      step(); hreset = 1'b0;
      drv(1, NONSEQ, 32'h2000_0100, 1'b0, 3'd3);
      push(0, 32'h4, "t6_g2_hsel"); push(1, 32'h1, "t6_g2_hready"); push(7, 32'h2000_0900, "t6_g2_haddr");
      step(); drv(0, IDLE, 32'h0, 1'b0, 3'd0);
      push(1, 32'h3, "t6_g3_hready"); push(7, 32'h2000_0100, "t6_g3_haddr");
      step(); idle();
      step();
      done = 1'b1;
      @(negedge hclk);
      @(negedge hclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
